// File: rtl/hood_pkg.sv
// Shared types, clock/debounce defaults and time helpers for the hood controllers
// (power_ctrl and mode_change).
package hood_pkg;

   localparam int unsigned CLK_HZ_DEF       = 100_000_000;
   localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;

   typedef enum logic [1:0] {
      ST_OFF           = 2'd0,
      ST_GEST_ON_WAIT  = 2'd1,
      ST_ON            = 2'd2,
      ST_GEST_OFF_WAIT = 2'd3
   } pwr_state_e;

   function automatic int unsigned sec_to_cyc(input int unsigned sec, input int unsigned clk_hz);
      return sec * clk_hz;
   endfunction

   function automatic logic is_powered(input pwr_state_e s);
      return (s == ST_ON) || (s == ST_GEST_OFF_WAIT);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus consecutive-difference counter for one raw button;
// emits the accepted stable level and a one-cycle rise pulse.
module btn_debounce
   import hood_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             level_dly_q, rise_q;

   // Any cycle that agrees with the stable level restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) level_d = sync2_q;
         else                                   cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         rise_q      <= 1'b0;
      end else begin
         sync1_q     <= btn_raw;
         sync2_q     <= sync1_q;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         rise_q      <= level_q & ~level_dly_q;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;

endmodule

// File: rtl/power_ctrl.sv
// Hood power sequencer: short press on, long press off, optional left/right gesture
// windows (POWER_GESTURE_EN). power_state gates the downstream mode_change FSM.
//
//   state            | meaning
//   ST_OFF           | hood unpowered
//   ST_GEST_ON_WAIT  | left seen while off; waiting for right within the window
//   ST_ON            | hood powered; power-button hold counts toward off
//   ST_GEST_OFF_WAIT | right seen while on; waiting for left within the window
module power_ctrl
   import hood_pkg::*;
#(
   parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int unsigned LONG_PRESS_S = 3,
   parameter int unsigned GESTURE_S    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_btn,
   input  logic       left_btn,
   input  logic       right_btn,
   input  logic [3:0] gesture_sec,
   output logic       power_state,
   output logic       power_on_pulse,
   output logic       hold_active,
   output logic [3:0] gesture_countdown
);

   localparam int unsigned HOLD_CYC = sec_to_cyc(LONG_PRESS_S, CLK_HZ);
   localparam int unsigned HOLD_W   = $clog2(HOLD_CYC + 1);

   pwr_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              pulse_q, pulse_d;
   logic              pwr_level, pwr_rise;
   logic              counting, hold_done;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pwr (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (power_btn),
      .btn_level (pwr_level),
      .btn_rise  (pwr_rise)
   );

   assign counting   = pwr_level && is_powered(state_q);
   assign hold_done  = counting && (hold_cnt_q == HOLD_W'(HOLD_CYC - 1));
   assign hold_cnt_d = (counting && !hold_done) ? hold_cnt_q + 1'b1 : '0;

`ifdef POWER_GESTURE_EN
   localparam int unsigned SEC_W = $clog2(CLK_HZ + 1);

   logic             left_rise, right_rise;
   logic             left_lvl_unused, right_lvl_unused;
   logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
   logic [3:0]       cd_q, cd_d, win_len;
   logic             sec_tick, win_load, win_expire;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (left_btn),
      .btn_level (left_lvl_unused),
      .btn_rise  (left_rise)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (right_btn),
      .btn_level (right_lvl_unused),
      .btn_rise  (right_rise)
   );

   assign sec_tick   = (sec_cnt_q == SEC_W'(CLK_HZ - 1));
   assign win_expire = sec_tick && (cd_q == 4'd1);
   assign win_len    = (gesture_sec == 4'd0) ? 4'(GESTURE_S) : gesture_sec;

   // Opening or reloading a window realigns the second boundary to the press.
   always_comb begin
      sec_cnt_d = sec_tick ? '0 : sec_cnt_q + 1'b1;
      if (win_load) sec_cnt_d = '0;
   end

   always_comb begin
      cd_d = cd_q;
      if (sec_tick && (cd_q != 4'd0)) cd_d = cd_q - 4'd1;
      if (win_load) cd_d = win_len;
      if ((state_d != ST_GEST_ON_WAIT) && (state_d != ST_GEST_OFF_WAIT)) cd_d = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sec_cnt_q <= '0;
         cd_q      <= 4'd0;
      end else begin
         sec_cnt_q <= sec_cnt_d;
         cd_q      <= cd_d;
      end
   end

   assign gesture_countdown = cd_q;
`else
   logic gest_unused;
   assign gest_unused       = ^{left_btn, right_btn, gesture_sec, 4'(GESTURE_S)};
   assign gesture_countdown = 4'd0;
`endif

   // Event priority: power rise, hold expiry, gesture completion, window expiry.
   always_comb begin
      state_d = state_q;
`ifdef POWER_GESTURE_EN
      win_load = 1'b0;
`endif
      case (state_q)
         ST_OFF: begin
            if (pwr_rise) state_d = ST_ON;
`ifdef POWER_GESTURE_EN
            else if (left_rise) begin
               state_d  = ST_GEST_ON_WAIT;
               win_load = 1'b1;
            end
`endif
         end
         ST_ON: begin
            if (hold_done) state_d = ST_OFF;
`ifdef POWER_GESTURE_EN
            else if (right_rise) begin
               state_d  = ST_GEST_OFF_WAIT;
               win_load = 1'b1;
            end
`endif
         end
`ifdef POWER_GESTURE_EN
         ST_GEST_ON_WAIT: begin
            if (pwr_rise || right_rise) state_d  = ST_ON;
            else if (left_rise)         win_load = 1'b1;
            else if (win_expire)        state_d  = ST_OFF;
         end
         ST_GEST_OFF_WAIT: begin
            if (hold_done || left_rise) state_d  = ST_OFF;
            else if (right_rise)        win_load = 1'b1;
            else if (win_expire)        state_d  = ST_ON;
         end
`endif
         default: state_d = ST_OFF;
      endcase
   end

   assign pulse_d = is_powered(state_d) && !is_powered(state_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_OFF;
         hold_cnt_q <= '0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         pulse_q    <= pulse_d;
      end
   end

   assign power_state    = is_powered(state_q);
   assign power_on_pulse = pulse_q;
   assign hold_active    = counting;

endmodule

// File: tb/tb_power_ctrl.sv
// Directed bench for power_ctrl at CLK_HZ=10, DEBOUNCE_CYC=4; gesture expectations
// follow whether POWER_GESTURE_EN is defined for the build.
module tb_power_ctrl;

`ifdef POWER_GESTURE_EN
   localparam bit GEST = 1'b1;
`else
   localparam bit GEST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       power_btn, left_btn, right_btn;
   logic [3:0] gesture_sec;
   logic       power_state, power_on_pulse, hold_active;
   logic [3:0] gesture_countdown;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   power_ctrl #(
      .CLK_HZ       (10),
      .DEBOUNCE_CYC (4),
      .LONG_PRESS_S (3),
      .GESTURE_S    (5)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .power_btn         (power_btn),
      .left_btn          (left_btn),
      .right_btn         (right_btn),
      .gesture_sec       (gesture_sec),
      .power_state       (power_state),
      .power_on_pulse    (power_on_pulse),
      .hold_active       (hold_active),
      .gesture_countdown (gesture_countdown)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ps"},    power_state,       4'd0);
      chk({tag, "_pulse"}, power_on_pulse,    4'd0);
      chk({tag, "_hold"},  hold_active,       4'd0);
      chk({tag, "_cd"},    gesture_countdown, 4'd0);
   endtask

   initial begin
      reset = 1'b1; power_btn = 1'b0; left_btn = 1'b0; right_btn = 1'b0; gesture_sec = 4'd0;
      tick(3);
      chk_all_zero("reset");
      reset = 1'b0;
      tick(2);

      // Short press turns on: rise at cycle 7, power_state at cycle 8.
      power_btn = 1'b1;
      tick(7); chk("on_pre", power_state, 4'd0);
      tick(1); chk("on_ps", power_state, 4'd1);
      chk("on_pulse", power_on_pulse, 4'd1);
      chk("on_hold", hold_active, 4'd1);
      tick(1); chk("on_pulse_end", power_on_pulse, 4'd0);
      power_btn = 1'b0;
      tick(15);
      chk("rel_hold", hold_active, 4'd0);
      chk("rel_ps", power_state, 4'd1);

      // 20-cycle press is below the 30-cycle hold.
      power_btn = 1'b1;
      tick(20); chk("short_hold", hold_active, 4'd1);
      chk("short_ps", power_state, 4'd1);
      power_btn = 1'b0;
      tick(12); chk("short_rel_hold", hold_active, 4'd0);
      chk("short_rel_ps", power_state, 4'd1);

      // While on, gesture_sec=0: right then left 10 cycles later.
      gesture_sec = 4'd0;
      right_btn = 1'b1; tick(6); right_btn = 1'b0; tick(2);
      chk("goff_cd5", gesture_countdown, GEST ? 4'd5 : 4'd0);
      chk("goff_open_ps", power_state, 4'd1);
      tick(2); left_btn = 1'b1; tick(6); left_btn = 1'b0;
      tick(1); chk("goff_pre_ps", power_state, 4'd1);
      chk("goff_pre_cd", gesture_countdown, GEST ? 4'd5 : 4'd0);
      tick(1); chk("goff_ps", power_state, GEST ? 4'd0 : 4'd1);
      chk("goff_cd0", gesture_countdown, 4'd0);
      tick(12);

      // Power press brings the hood back on (already on without gestures).
      power_btn = 1'b1; tick(8);
      chk("reon_ps", power_state, 4'd1);
      chk("reon_pulse", power_on_pulse, GEST ? 4'd1 : 4'd0);
      power_btn = 1'b0; tick(16);

      // Right with no left: countdown 5..1 then expires back to on.
      right_btn = 1'b1; tick(6); right_btn = 1'b0; tick(2);
      chk("exp_cd5", gesture_countdown, GEST ? 4'd5 : 4'd0);
      tick(10); chk("exp_cd4", gesture_countdown, GEST ? 4'd4 : 4'd0);
      tick(39); chk("exp_cd1", gesture_countdown, GEST ? 4'd1 : 4'd0);
      chk("exp_ps_in", power_state, 4'd1);
      tick(1); chk("exp_cd0", gesture_countdown, 4'd0);
      chk("exp_ps_on", power_state, 4'd1);

      // Long hold: off exactly 30 cycles after the stable level (cycle 36).
      power_btn = 1'b1;
      tick(35); chk("hold_pre_ps", power_state, 4'd1);
      chk("hold_pre_act", hold_active, 4'd1);
      tick(1); chk("hold_off_ps", power_state, 4'd0);
      chk("hold_off_act", hold_active, 4'd0);
      tick(9); chk("hold_stay_ps", power_state, 4'd0);
      power_btn = 1'b0; tick(12);
      chk("hold_rel_ps", power_state, 4'd0);

      // While off, gesture_sec=2: left, then right 15 cycles later.
      gesture_sec = 4'd2;
      left_btn = 1'b1; tick(6); left_btn = 1'b0; tick(2);
      chk("gon_cd2", gesture_countdown, GEST ? 4'd2 : 4'd0);
      chk("gon_open_ps", power_state, 4'd0);
      tick(7); right_btn = 1'b1;
      tick(4); chk("gon_cd1", gesture_countdown, GEST ? 4'd1 : 4'd0);
      tick(2); right_btn = 1'b0;
      tick(1); chk("gon_pre_ps", power_state, 4'd0);
      tick(1); chk("gon_ps", power_state, GEST ? 4'd1 : 4'd0);
      chk("gon_pulse", power_on_pulse, GEST ? 4'd1 : 4'd0);
      chk("gon_cd0", gesture_countdown, 4'd0);
      tick(12);

      // Right then left turns off again (stays off without gestures).
      right_btn = 1'b1; tick(6); right_btn = 1'b0; tick(4);
      left_btn = 1'b1; tick(6); left_btn = 1'b0; tick(2);
      chk("goff2_ps", power_state, 4'd0);
      tick(12);

      // Left, right too late at 25 cycles: window 2->1->0 expires to off.
      left_btn = 1'b1; tick(6); left_btn = 1'b0; tick(2);
      chk("late_cd2", gesture_countdown, GEST ? 4'd2 : 4'd0);
      tick(10); chk("late_cd1", gesture_countdown, GEST ? 4'd1 : 4'd0);
      tick(7); right_btn = 1'b1;
      tick(2); chk("late_cd1b", gesture_countdown, GEST ? 4'd1 : 4'd0);
      tick(1); chk("late_cd0", gesture_countdown, 4'd0);
      chk("late_ps", power_state, 4'd0);
      tick(3); right_btn = 1'b0;
      tick(2); chk("late_right_ps", power_state, 4'd0);
      tick(12);

      // Press after the long-press off powers on; reset mid-hold aborts.
      power_btn = 1'b1; tick(8);
      chk("again_ps", power_state, 4'd1);
      chk("again_pulse", power_on_pulse, 4'd1);
      tick(12); chk("midhold_act", hold_active, 4'd1);
      reset = 1'b1; power_btn = 1'b0;
      tick(1); chk_all_zero("rst_hold");
      reset = 1'b0;
      tick(10); chk("rst_hold_after_ps", power_state, 4'd0);

      // Reset mid-window.
      left_btn = 1'b1; tick(6); left_btn = 1'b0; tick(4);
      chk("midwin_cd", gesture_countdown, GEST ? 4'd2 : 4'd0);
      reset = 1'b1;
      tick(1); chk_all_zero("rst_win");
      reset = 1'b0;
      tick(25);
      chk("rst_win_after_ps", power_state, 4'd0);
      chk("rst_win_after_cd", gesture_countdown, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
